// File: rtl/fram_wb_arbiter.sv
// rtl/fram_wb_arbiter.sv - feature-SRAM port-B arbiter between decoder reads and queued CU writebacks
module fram_wb_arbiter #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int BANK_NUM    = 4,
    parameter int WBUF_DEPTH  = 4,
    parameter int STALL_LIMIT = 8,
    localparam int BANK_BITS       = $clog2(BANK_NUM),
    localparam int BANK_ADDR_WIDTH = ADDR_WIDTH - BANK_BITS,
    localparam int PTR_W           = $clog2(WBUF_DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rp_en,
    input  logic [ADDR_WIDTH-1:0]               rp_addr,
    output logic                                rp_ready,
    output logic                                rp_rvalid,
    output logic [DATA_WIDTH-1:0]               rp_rdata,
    input  logic                                wp_valid,
    input  logic [ADDR_WIDTH-1:0]               wp_addr,
    input  logic [DATA_WIDTH-1:0]               wp_wdata,
    output logic                                wp_ready,
    output logic [BANK_NUM*BANK_ADDR_WIDTH-1:0] bram_addr,
    output logic [BANK_NUM*DATA_WIDTH-1:0]      bram_wdata,
    output logic [BANK_NUM-1:0]                 bram_we,
    output logic [BANK_NUM-1:0]                 bram_en,
    input  logic [BANK_NUM*DATA_WIDTH-1:0]      bram_rdata,
    output logic [PTR_W:0]                      wbuf_count,
    output logic                                idle,
    output logic                                raw_hazard,
    input  logic                                hazard_clr
);

    localparam int SW       = $clog2(STALL_LIMIT + 1);
    // force_wr is registered, so it must be raised one blocked cycle before the forced cycle
    localparam int FORCE_AT = (STALL_LIMIT >= 2) ? STALL_LIMIT - 2 : 0;

    logic [ADDR_WIDTH-1:0] q_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [WBUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W:0]        count;
    logic [SW-1:0]         stall_cnt;
    logic                  force_wr;
    logic [BANK_BITS-1:0]  sel_q;

    logic                  empty;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [BANK_BITS-1:0]  head_bank;
    logic [BANK_BITS-1:0]  rd_bank;
    logic                  same_bank;
    logic                  issue;
    logic                  blocked;
    logic                  rd_acc;
    logic                  push;
    logic [WBUF_DEPTH-1:0] entry_hit;

    assign empty      = (count == '0);
    assign head_addr  = q_addr[rd_ptr];
    assign head_data  = q_data[rd_ptr];
    assign head_bank  = head_addr[BANK_BITS-1:0];
    assign rd_bank    = rp_addr[BANK_BITS-1:0];
    assign same_bank  = (rd_bank == head_bank);
    assign issue      = !empty && (!rp_en || !same_bank || force_wr);
    assign blocked    = !empty && !issue;
    assign rp_ready   = !(force_wr && !empty && same_bank);
    assign rd_acc     = rp_en && rp_ready;
    assign wp_ready   = (count != (PTR_W+1)'(WBUF_DEPTH));
    assign push       = wp_valid && wp_ready;
    assign wbuf_count = count;
    assign idle       = empty;

    // an entry is live when its offset from the head is below the occupancy
    for (genvar i = 0; i < WBUF_DEPTH; i++) begin : g_match
        logic [PTR_W-1:0] off;
        assign off          = PTR_W'(i) - rd_ptr;
        assign entry_hit[i] = ({1'b0, off} < count) && (q_addr[i] == rp_addr);
    end

    always_comb begin
        bram_en    = '0;
        bram_we    = '0;
        bram_addr  = '0;
        bram_wdata = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (issue && (head_bank == BANK_BITS'(b))) begin
                bram_en[b]                                   = 1'b1;
                bram_we[b]                                   = 1'b1;
                bram_addr[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = head_addr[ADDR_WIDTH-1:BANK_BITS];
                bram_wdata[b*DATA_WIDTH +: DATA_WIDTH]        = head_data;
            end else if (rd_acc && (rd_bank == BANK_BITS'(b))) begin
                bram_en[b]                                   = 1'b1;
                bram_addr[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = rp_addr[ADDR_WIDTH-1:BANK_BITS];
            end
        end
    end

    always_comb begin
        rp_rdata = '0;
        if (rp_rvalid) begin
            rp_rdata = bram_rdata[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= wp_addr;
            q_data[wr_ptr] <= wp_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            stall_cnt  <= '0;
            force_wr   <= 1'b0;
            rp_rvalid  <= 1'b0;
            sel_q      <= '0;
            raw_hazard <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase

            if (empty || issue) begin
                stall_cnt <= '0;
            end else if (stall_cnt != SW'(STALL_LIMIT)) begin
                stall_cnt <= stall_cnt + SW'(1);
            end

            if (issue) begin
                force_wr <= 1'b0;
            end else if (blocked && (stall_cnt >= SW'(FORCE_AT))) begin
                force_wr <= 1'b1;
            end

            rp_rvalid <= rd_acc;
            if (rd_acc) begin
                sel_q <= rd_bank;
            end

            if (rd_acc && (|entry_hit)) begin
                raw_hazard <= 1'b1;
            end else if (hazard_clr) begin
                raw_hazard <= 1'b0;
            end
        end
    end

endmodule
